// File: rtl/lsu_if.sv
// Execute/writeback/data-memory bundle of the load-store port.
// The master side is the environment: the execute stage, the writeback stage and the data memory.
interface lsu_if;
    // req/resp: a beat transfers on a rising edge where valid && ready. valid and payload are held
    // until that edge. ready may depend on state but never on the same-cycle valid.
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read_req;
    logic        mem_write_req;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata_raw;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata_raw,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_read_req, mem_write_req, mem_byte_en
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata_raw,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_read_req, mem_write_req, mem_byte_en
    );
endinterface

// File: rtl/lsu_port.sv
// RV32I load-store port: aligns byte/half/word accesses onto a word-wide data memory.
// Accesses that cross a word boundary are split into two beats, or rejected when SPLIT_EN is 0.
module lsu_port #(
    parameter bit          SPLIT_EN  = 1'b1,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_if.slave       bus,
    output logic [1:0] fsm_state
);
    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

    state_t      state;
    logic        q_we;
    logic [2:0]  q_f3;
    logic [1:0]  q_off;
    logic [3:0]  q_hi_mask;
    logic [31:0] q_wdata;
    logic [31:0] lo_q;

    logic [1:0]  in_off;
    logic [3:0]  in_base;
    logic [7:0]  in_mask;
    logic        in_cross;
    logic        in_fmt_ok;
    logic        in_legal;
    logic [31:0] in_wd1;
    logic [5:0]  sh2;
    logic [31:0] wd2;

    assign in_off   = bus.req_addr[1:0];
    assign in_mask  = {4'b0000, in_base} << in_off;
    assign in_cross = |in_mask[7:4];
    assign in_legal = in_fmt_ok && (SPLIT_EN || !in_cross);
    assign in_wd1   = bus.req_wdata << {in_off, 3'b000};
    // The upper store bytes that spilled past the first word land in the low lanes of the next word.
    assign sh2      = 6'd32 - {1'b0, q_off, 3'b000};
    assign wd2      = q_wdata >> sh2;

    assign bus.req_ready = (state == IDLE);
    assign fsm_state     = state;

    always_comb begin
        in_base = 4'hF;
        case (bus.req_funct3[1:0])
            2'd0:    in_base = 4'h1;
            2'd1:    in_base = 4'h3;
            default: in_base = 4'hF;
        endcase
    end

    always_comb begin
        in_fmt_ok = 1'b0;
        if (bus.req_we) begin
            in_fmt_ok = (bus.req_funct3 <= 3'd2);
        end else begin
            case (bus.req_funct3)
                3'd0, 3'd1, 3'd2, 3'd4, 3'd5: in_fmt_ok = 1'b1;
                default:                      in_fmt_ok = 1'b0;
            endcase
        end
    end

    // {hi,lo} is the 8-byte window starting at the aligned word; shifting by the offset brings the
    // addressed byte to lane 0, and the size/sign code then trims and extends it.
    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] hi, input logic [31:0] lo);
        logic [31:0] w;
        w = 32'({hi, lo} >> {off, 3'b000});
        case (f3)
            3'd0:    load_ext = {{24{w[7]}}, w[7:0]};
            3'd1:    load_ext = {{16{w[15]}}, w[15:0]};
            3'd4:    load_ext = {24'h0, w[7:0]};
            3'd5:    load_ext = {16'h0, w[15:0]};
            default: load_ext = w;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            q_we              <= 1'b0;
            q_f3              <= 3'd0;
            q_off             <= 2'd0;
            q_hi_mask         <= 4'h0;
            q_wdata           <= 32'h0;
            lo_q              <= 32'h0;
            bus.resp_valid    <= 1'b0;
            bus.resp_rdata    <= 32'h0;
            bus.resp_err      <= 1'b0;
            bus.mem_addr      <= 32'h0;
            bus.mem_wdata     <= 32'h0;
            bus.mem_read_req  <= 1'b0;
            bus.mem_write_req <= 1'b0;
            bus.mem_byte_en   <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        q_we      <= bus.req_we;
                        q_f3      <= bus.req_funct3;
                        q_off     <= in_off;
                        q_hi_mask <= in_mask[7:4];
                        q_wdata   <= bus.req_wdata;
                        if (in_legal) begin
                            state             <= BEAT1;
                            bus.mem_addr      <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_byte_en   <= in_mask[3:0];
                            bus.mem_wdata     <= in_wd1;
                            bus.mem_read_req  <= !bus.req_we;
                            bus.mem_write_req <= bus.req_we;
                        end else begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= ERR_RDATA;
                        end
                    end
                end
                BEAT1: begin
                    lo_q <= bus.mem_rdata_raw;
                    if (|q_hi_mask) begin
                        state           <= BEAT2;
                        bus.mem_addr    <= bus.mem_addr + 32'd4;
                        bus.mem_byte_en <= q_hi_mask;
                        bus.mem_wdata   <= wd2;
                    end else begin
                        state             <= RESP;
                        bus.mem_addr      <= 32'h0;
                        bus.mem_wdata     <= 32'h0;
                        bus.mem_read_req  <= 1'b0;
                        bus.mem_write_req <= 1'b0;
                        bus.mem_byte_en   <= 4'h0;
                        bus.resp_valid    <= 1'b1;
                        bus.resp_err      <= 1'b0;
                        bus.resp_rdata    <= q_we ? 32'h0
                                                  : load_ext(q_f3, q_off, 32'h0, bus.mem_rdata_raw);
                    end
                end
                BEAT2: begin
                    state             <= RESP;
                    bus.mem_addr      <= 32'h0;
                    bus.mem_wdata     <= 32'h0;
                    bus.mem_read_req  <= 1'b0;
                    bus.mem_write_req <= 1'b0;
                    bus.mem_byte_en   <= 4'h0;
                    bus.resp_valid    <= 1'b1;
                    bus.resp_err      <= 1'b0;
                    bus.resp_rdata    <= q_we ? 32'h0
                                              : load_ext(q_f3, q_off, bus.mem_rdata_raw, lo_q);
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        bus.resp_valid <= 1'b0;
                        bus.resp_err   <= 1'b0;
                        bus.resp_rdata <= 32'h0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_port.sv
// Directed bench for lsu_port: a split-enabled port on a byte memory model and a split-disabled
// port on a constant read bus.
module tb_lsu_port;
    logic       clk;
    logic       rst_n;
    logic [1:0] st0;
    logic [1:0] st1;
    int         n_cmp = 0;
    int         n_err = 0;

    lsu_if bus0 ();
    lsu_if bus1 ();

    lsu_port #(.SPLIT_EN(1'b1), .ERR_RDATA(32'hDEAD_BEEF)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .fsm_state(st0));
    lsu_port #(.SPLIT_EN(1'b0), .ERR_RDATA(32'hDEAD_BEEF)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .fsm_state(st1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory (address bits [9:0]) with a poke port for preloading.
    logic [7:0]  mem [0:1023];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_addr = 10'h0;
    logic [7:0]  poke_data = 8'h0;
    logic [9:0]  ma;
    logic [31:0] beat_addr [64];
    logic [3:0]  beat_en   [64];
    logic [31:0] beat_wd   [64];
    logic        beat_wr   [64];
    int          beat_cnt = 0;

    assign ma = bus0.mem_addr[9:0];
    assign bus0.mem_rdata_raw = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
    assign bus1.mem_rdata_raw = 32'h5566_7788;

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        if (bus0.mem_read_req || bus0.mem_write_req) begin
            beat_addr[beat_cnt[5:0]] <= bus0.mem_addr;
            beat_en[beat_cnt[5:0]]   <= bus0.mem_byte_en;
            beat_wd[beat_cnt[5:0]]   <= bus0.mem_wdata;
            beat_wr[beat_cnt[5:0]]   <= bus0.mem_write_req;
            beat_cnt <= beat_cnt + 1;
            for (int i = 0; i < 4; i++)
                if (bus0.mem_write_req && bus0.mem_byte_en[i])
                    mem[ma + 10'(i)] <= bus0.mem_wdata[8*i +: 8];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                          output logic er, output int nb, output int base);
        @(negedge clk);
        bus0.req_valid  = 1'b1;
        bus0.req_we     = we;
        bus0.req_funct3 = f3;
        bus0.req_addr   = addr;
        bus0.req_wdata  = wdata;
        base = beat_cnt;
        @(posedge clk);
        #1 bus0.req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            @(negedge clk);
            if (bus0.resp_valid) lat = i;
        end
        rd = bus0.resp_rdata;
        er = bus0.resp_err;
        nb = beat_cnt - base;
        check("resp.mem_addr", bus0.mem_addr, 32'h0);
        check("resp.strobes", {26'h0, bus0.mem_read_req, bus0.mem_write_req, bus0.mem_byte_en}, 32'h0);
        check("resp.req_ready", {31'h0, bus0.req_ready}, 32'h0);
        bus0.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus0.resp_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                       input logic [31:0] exp_rd, input logic exp_er, input int exp_nb,
                       output int base);
        int lat;
        int nb;
        logic [31:0] rd;
        logic er;
        do_req(we, f3, addr, wdata, lat, rd, er, nb, base);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".rdata"}, rd, exp_rd);
        check({tag, ".err"}, {31'h0, er}, {31'h0, exp_er});
        check({tag, ".beats"}, nb, exp_nb);
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [31:0] a,
                            input logic [3:0] en, input logic [31:0] wd, input logic wr);
        check({tag, ".addr"}, beat_addr[idx[5:0]], a);
        check({tag, ".byte_en"}, {28'h0, beat_en[idx[5:0]]}, {28'h0, en});
        check({tag, ".wdata"}, beat_wd[idx[5:0]], wd);
        check({tag, ".write"}, {31'h0, beat_wr[idx[5:0]]}, {31'h0, wr});
    endtask

    task automatic chk_reset_outputs(input string tag);
        check({tag, ".req_ready"}, {31'h0, bus0.req_ready}, 32'h1);
        check({tag, ".resp_valid"}, {31'h0, bus0.resp_valid}, 32'h0);
        check({tag, ".resp_err"}, {31'h0, bus0.resp_err}, 32'h0);
        check({tag, ".resp_rdata"}, bus0.resp_rdata, 32'h0);
        check({tag, ".mem_addr"}, bus0.mem_addr, 32'h0);
        check({tag, ".mem_wdata"}, bus0.mem_wdata, 32'h0);
        check({tag, ".strobes"}, {26'h0, bus0.mem_read_req, bus0.mem_write_req, bus0.mem_byte_en}, 32'h0);
        check({tag, ".state"}, {30'h0, st0}, 32'h0);
    endtask

    initial begin
        int b;
        rst_n = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = 3'd0;
        bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0; bus0.resp_ready = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = 3'd0;
        bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0; bus1.resp_ready = 1'b0;
        #1;
        chk_reset_outputs("reset");
        check("reset.dut1_ready", {31'h0, bus1.req_ready}, 32'h1);

        poke(10'h100, 8'h78); poke(10'h101, 8'h56); poke(10'h102, 8'h34); poke(10'h103, 8'h12);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // First request right after reset release.
        run("lw100", 1'b0, 3'd2, 32'h100, 32'h0, 2, 32'h1234_5678, 1'b0, 1, b);
        chk_beat("lw100.b1", b, 32'h100, 4'hF, 32'h0, 1'b0);

        poke(10'h103, 8'h80);
        run("lb103", 1'b0, 3'd0, 32'h103, 32'h0, 2, 32'hFFFF_FF80, 1'b0, 1, b);
        chk_beat("lb103.b1", b, 32'h100, 4'h8, 32'h0, 1'b0);
        run("lbu103", 1'b0, 3'd4, 32'h103, 32'h0, 2, 32'h0000_0080, 1'b0, 1, b);
        run("lh102", 1'b0, 3'd1, 32'h102, 32'h0, 2, 32'hFFFF_8034, 1'b0, 1, b);
        chk_beat("lh102.b1", b, 32'h100, 4'hC, 32'h0, 1'b0);
        run("lhu102", 1'b0, 3'd5, 32'h102, 32'h0, 2, 32'h0000_8034, 1'b0, 1, b);

        run("sw102", 1'b1, 3'd2, 32'h102, 32'hAABB_CCDD, 3, 32'h0, 1'b0, 2, b);
        chk_beat("sw102.b1", b, 32'h100, 4'hC, 32'hCCDD_0000, 1'b1);
        chk_beat("sw102.b2", b + 1, 32'h104, 4'h3, 32'h0000_AABB, 1'b1);
        run("lw102", 1'b0, 3'd2, 32'h102, 32'h0, 3, 32'hAABB_CCDD, 1'b0, 2, b);
        chk_beat("lw102.b2", b + 1, 32'h104, 4'h3, 32'h0, 1'b0);

        run("sb101", 1'b1, 3'd0, 32'h101, 32'h1234_56EF, 2, 32'h0, 1'b0, 1, b);
        chk_beat("sb101.b1", b, 32'h100, 4'h2, 32'h3456_EF00, 1'b1);
        run("lbu101", 1'b0, 3'd4, 32'h101, 32'h0, 2, 32'h0000_00EF, 1'b0, 1, b);

        // Half-word straddling the top of the address space wraps to word 0.
        run("shwrap", 1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_BEEF, 3, 32'h0, 1'b0, 2, b);
        chk_beat("shwrap.b1", b, 32'hFFFF_FFFC, 4'h8, 32'hEF00_0000, 1'b1);
        chk_beat("shwrap.b2", b + 1, 32'h0000_0000, 4'h1, 32'h0000_00BE, 1'b1);
        run("lhwrap", 1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0, 3, 32'hFFFF_BEEF, 1'b0, 2, b);

        run("sd_bad", 1'b1, 3'd3, 32'h100, 32'h1111_1111, 1, 32'hDEAD_BEEF, 1'b1, 0, b);
        run("ld6_bad", 1'b0, 3'd6, 32'h100, 32'h0, 1, 32'hDEAD_BEEF, 1'b1, 0, b);

        // Illegal load with writeback stalled for five cycles.
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_funct3 = 3'd3;
        bus0.req_addr = 32'h200; bus0.req_wdata = 32'h0;
        @(posedge clk);
        #1 bus0.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold.resp_valid", {31'h0, bus0.resp_valid}, 32'h1);
            check("hold.resp_err", {31'h0, bus0.resp_err}, 32'h1);
            check("hold.resp_rdata", bus0.resp_rdata, 32'hDEAD_BEEF);
            check("hold.req_ready", {31'h0, bus0.req_ready}, 32'h0);
            check("hold.read_req", {31'h0, bus0.mem_read_req}, 32'h0);
        end
        bus0.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus0.resp_ready = 1'b0;
        @(negedge clk);
        check("hold.after_ready", {31'h0, bus0.req_ready}, 32'h1);
        check("hold.after_valid", {31'h0, bus0.resp_valid}, 32'h0);

        // Reset during beat 2 of a split store.
        poke(10'h102, 8'h00); poke(10'h103, 8'h00); poke(10'h104, 8'h00); poke(10'h105, 8'h00);
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_funct3 = 3'd2;
        bus0.req_addr = 32'h102; bus0.req_wdata = 32'hAABB_CCDD;
        @(posedge clk);
        #1 bus0.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst2.in_beat2", bus0.mem_addr, 32'h104);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst2");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst2.mem102", {24'h0, mem[10'h102]}, 32'hDD);
        check("rst2.mem103", {24'h0, mem[10'h103]}, 32'hCC);
        check("rst2.mem104", {24'h0, mem[10'h104]}, 32'h00);
        check("rst2.mem105", {24'h0, mem[10'h105]}, 32'h00);
        repeat (3) begin
            @(negedge clk);
            check("rst2.no_resp", {31'h0, bus0.resp_valid}, 32'h0);
        end
        run("lw_after_rst", 1'b0, 3'd2, 32'h100, 32'h0, 2, 32'hCCDD_EF78, 1'b0, 1, b);

        // Split-disabled port: a crossing half-word is rejected without touching memory.
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_funct3 = 3'd1; bus1.req_addr = 32'h103;
        @(posedge clk);
        #1 bus1.req_valid = 1'b0;
        @(negedge clk);
        check("nosplit.resp_valid", {31'h0, bus1.resp_valid}, 32'h1);
        check("nosplit.resp_err", {31'h0, bus1.resp_err}, 32'h1);
        check("nosplit.resp_rdata", bus1.resp_rdata, 32'hDEAD_BEEF);
        check("nosplit.strobes", {26'h0, bus1.mem_read_req, bus1.mem_write_req, bus1.mem_byte_en}, 32'h0);
        bus1.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus1.resp_ready = 1'b0;

        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_funct3 = 3'd2; bus1.req_addr = 32'h100;
        @(posedge clk);
        #1 bus1.req_valid = 1'b0;
        @(negedge clk);
        check("nosplit_lw.read_req", {31'h0, bus1.mem_read_req}, 32'h1);
        check("nosplit_lw.byte_en", {28'h0, bus1.mem_byte_en}, 32'hF);
        check("nosplit_lw.addr", bus1.mem_addr, 32'h100);
        check("nosplit_lw.state", {30'h0, st1}, 32'h1);
        @(negedge clk);
        check("nosplit_lw.resp_valid", {31'h0, bus1.resp_valid}, 32'h1);
        check("nosplit_lw.rdata", bus1.resp_rdata, 32'h5566_7788);
        check("nosplit_lw.err", {31'h0, bus1.resp_err}, 32'h0);
        bus1.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus1.resp_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
